// File: rtl/conflict_free_map_pipe.sv
// Bank mapper for LANES flat addresses: splits each into bank/row under a per-beat
// scheme, then passes results through a 2-stage valid/ready pipe with conflict flagging.
module conflict_free_map_pipe #(
    parameter int LANES  = 8,
    parameter int ADDR_W = 10,
    parameter int BANK_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [1:0]                        in_mode,
    input  logic [LANES-1:0]                  in_en,
    input  logic [LANES*ADDR_W-1:0]           in_addr,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [LANES-1:0]                  out_en,
    output logic [LANES*BANK_W-1:0]           out_bank,
    output logic [LANES*(ADDR_W-BANK_W)-1:0]  out_row,
    output logic                              out_conflict,
    input  logic                              cnt_clr,
    output logic [CNT_W-1:0]                  conflict_cnt
);

    localparam int ROW_W = ADDR_W - BANK_W;
    localparam int NDIG  = (ADDR_W + BANK_W - 1) / BANK_W;
    localparam int PAD_W = NDIG * BANK_W;

    logic                      v1, v2;
    logic                      adv1, adv2;
    logic [LANES*BANK_W-1:0]   bank_d, bank1, bank2;
    logic [LANES*ROW_W-1:0]    row_d, row1, row2;
    logic [LANES-1:0]          en1, en2;
    logic                      conf_d, conf2;

    assign adv2     = !v2 || out_ready;
    assign adv1     = !v1 || adv2;
    assign in_ready = adv1;

    // Per-lane bank selection; row is always the upper address bits.
    always_comb begin
        logic [ADDR_W-1:0] a;
        logic [PAD_W-1:0]  pa;
        logic [BANK_W-1:0] b;
        logic [BANK_W-1:0] dsum;
        logic              p;
        bank_d = '0;
        row_d  = '0;
        for (int i = 0; i < LANES; i++) begin
            a    = in_addr[i*ADDR_W +: ADDR_W];
            p    = ^a[ADDR_W-1:BANK_W];
            pa   = PAD_W'(a);
            dsum = '0;
            for (int d = 0; d < NDIG; d++) begin
                dsum = dsum + pa[d*BANK_W +: BANK_W];
            end
            b = a[BANK_W-1:0];
            case (in_mode)
                2'd0: b[BANK_W-1] = b[BANK_W-1] ^ p;
                2'd1: b = dsum;
                default: ;
            endcase
            bank_d[i*BANK_W +: BANK_W] = b;
            row_d[i*ROW_W +: ROW_W]    = a[ADDR_W-1:BANK_W];
        end
    end

    always_comb begin
        conf_d = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            for (int j = i + 1; j < LANES; j++) begin
                if (en1[i] && en1[j] &&
                    (bank1[i*BANK_W +: BANK_W] == bank1[j*BANK_W +: BANK_W])) begin
                    conf_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1    <= 1'b0;
            bank1 <= '0;
            row1  <= '0;
            en1   <= '0;
        end else if (adv1) begin
            v1 <= in_valid;
            if (in_valid) begin
                bank1 <= bank_d;
                row1  <= row_d;
                en1   <= in_en;
            end
        end
    end

    // Stage 2 refills from stage 1 whenever it is empty or draining.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v2    <= 1'b0;
            bank2 <= '0;
            row2  <= '0;
            en2   <= '0;
            conf2 <= 1'b0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                bank2 <= bank1;
                row2  <= row1;
                en2   <= en1;
                conf2 <= conf_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflict_cnt <= '0;
        end else if (cnt_clr) begin
            conflict_cnt <= '0;
        end else if (v2 && out_ready && conf2 && (conflict_cnt != {CNT_W{1'b1}})) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

    assign out_valid    = v2;
    assign out_bank     = bank2;
    assign out_row      = row2;
    assign out_en       = en2;
    assign out_conflict = conf2;

endmodule

// File: tb/tb_conflict_free_map_pipe.sv
// Directed bench for conflict_free_map_pipe: mapping modes, conflict flag,
// backpressure, counter saturation/clear and asynchronous reset.
module tb_conflict_free_map_pipe;

    localparam int LANES  = 8;
    localparam int ADDR_W = 10;
    localparam int BANK_W = 3;
    localparam int CNT_W  = 2;
    localparam int ROW_W  = ADDR_W - BANK_W;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      in_valid;
    logic                      in_ready;
    logic [1:0]                in_mode;
    logic [LANES-1:0]          in_en;
    logic [LANES*ADDR_W-1:0]   in_addr;
    logic                      out_valid;
    logic                      out_ready;
    logic [LANES-1:0]          out_en;
    logic [LANES*BANK_W-1:0]   out_bank;
    logic [LANES*ROW_W-1:0]    out_row;
    logic                      out_conflict;
    logic                      cnt_clr;
    logic [CNT_W-1:0]          conflict_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    conflict_free_map_pipe #(
        .LANES(LANES), .ADDR_W(ADDR_W), .BANK_W(BANK_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_en(in_en), .in_addr(in_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_en(out_en),
        .out_bank(out_bank), .out_row(out_row), .out_conflict(out_conflict),
        .cnt_clr(cnt_clr), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic set_lane(input int i, input logic [ADDR_W-1:0] a);
        in_addr[i*ADDR_W +: ADDR_W] = a;
    endtask

    // Offer one beat with out_ready high; returns once it sits in the output stage.
    task automatic beat(input logic [1:0] mode, input logic [LANES-1:0] en);
        in_mode  = mode;
        in_en    = en;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("lat_not_yet", {63'd0, out_valid}, 64'd0);
        tick();
    endtask

    initial begin
        logic [LANES*BANK_W-1:0] exp_bank;

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_mode   = 2'd0;
        in_en     = '0;
        in_addr   = '0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_bank", {40'd0, out_bank}, 64'd0);
        chk("rst_out_row", {8'd0, out_row}, 64'd0);
        chk("rst_out_conflict", {63'd0, out_conflict}, 64'd0);
        chk("rst_cnt", {62'd0, conflict_cnt}, 64'd0);

        // Mode 0 parity flip
        set_lane(0, 10'h009);
        set_lane(1, 10'h000);
        beat(2'd0, 8'h03);
        chk("m0_valid", {63'd0, out_valid}, 64'd1);
        chk("m0_bank0", {61'd0, out_bank[2:0]}, 64'd5);
        chk("m0_row0", {57'd0, out_row[6:0]}, 64'd1);
        chk("m0_bank1", {61'd0, out_bank[5:3]}, 64'd0);
        chk("m0_row1", {57'd0, out_row[13:7]}, 64'd0);
        chk("m0_conflict", {63'd0, out_conflict}, 64'd0);
        chk("m0_en", {56'd0, out_en}, 64'h03);
        tick();
        chk("m0_drained", {63'd0, out_valid}, 64'd0);

        // Mode 1 digit sum
        set_lane(0, 10'h009);
        beat(2'd1, 8'h01);
        chk("m1_bank0", {61'd0, out_bank[2:0]}, 64'd2);
        chk("m1_row0", {57'd0, out_row[6:0]}, 64'd1);
        tick();

        // Mode 2 identity: lanes 0 and 1 collide on bank 0
        set_lane(0, 10'h000);
        set_lane(1, 10'h008);
        beat(2'd2, 8'h03);
        chk("m2_bank0", {61'd0, out_bank[2:0]}, 64'd0);
        chk("m2_bank1", {61'd0, out_bank[5:3]}, 64'd0);
        chk("m2_conflict", {63'd0, out_conflict}, 64'd1);
        chk("m2_cnt_before", {62'd0, conflict_cnt}, 64'd0);
        tick();
        chk("m2_cnt_after", {62'd0, conflict_cnt}, 64'd1);

        // Same addresses in mode 0 separate the banks
        beat(2'd0, 8'h03);
        chk("m0b_bank0", {61'd0, out_bank[2:0]}, 64'd0);
        chk("m0b_bank1", {61'd0, out_bank[5:3]}, 64'd4);
        chk("m0b_conflict", {63'd0, out_conflict}, 64'd0);
        tick();
        chk("m0b_cnt", {62'd0, conflict_cnt}, 64'd1);

        // Mode 3 identity, all lanes distinct
        exp_bank = '0;
        for (int i = 0; i < LANES; i++) begin
            set_lane(i, ADDR_W'(i));
            exp_bank[i*BANK_W +: BANK_W] = BANK_W'(i);
        end
        beat(2'd3, 8'hFF);
        chk("all_lanes_bank", {40'd0, out_bank}, {40'd0, exp_bank});
        chk("all_lanes_conflict", {63'd0, out_conflict}, 64'd0);
        tick();

        // All lanes disabled, all colliding addresses
        in_addr = '0;
        beat(2'd2, 8'h00);
        chk("en0_valid", {63'd0, out_valid}, 64'd1);
        chk("en0_conflict", {63'd0, out_conflict}, 64'd0);
        tick();

        // Backpressure: A, B buffered, C refused until out_ready rises
        out_ready = 1'b0;
        in_mode   = 2'd2;
        in_en     = 8'h01;
        in_valid  = 1'b1;
        set_lane(0, 10'h001);
        #1;
        chk("bp_ready_a", {63'd0, in_ready}, 64'd1);
        tick();
        set_lane(0, 10'h002);
        #1;
        chk("bp_ready_b", {63'd0, in_ready}, 64'd1);
        tick();
        set_lane(0, 10'h003);
        #1;
        chk("bp_ready_c", {63'd0, in_ready}, 64'd0);
        chk("bp_valid_a", {63'd0, out_valid}, 64'd1);
        chk("bp_bank_a", {61'd0, out_bank[2:0]}, 64'd1);
        tick();
        chk("bp_hold_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_hold_bank", {61'd0, out_bank[2:0]}, 64'd1);
        chk("bp_hold_ready", {63'd0, in_ready}, 64'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_comb", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_out_b_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_out_b", {61'd0, out_bank[2:0]}, 64'd2);
        tick();
        chk("bp_out_c_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_out_c", {61'd0, out_bank[2:0]}, 64'd3);
        tick();
        chk("bp_empty", {63'd0, out_valid}, 64'd0);

        // Counter clear, then saturation over 5 conflicting beats
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("cnt_cleared", {62'd0, conflict_cnt}, 64'd0);
        in_addr  = '0;
        set_lane(1, 10'h008);
        in_mode  = 2'd2;
        in_en    = 8'h03;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("cnt_sat_drained", {63'd0, out_valid}, 64'd0);
        chk("cnt_saturated", {62'd0, conflict_cnt}, 64'd3);

        // Clear wins over a same-cycle conflicting handoff
        beat(2'd2, 8'h03);
        chk("clr_race_conflict", {63'd0, out_conflict}, 64'd1);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_wins", {62'd0, conflict_cnt}, 64'd0);
        beat(2'd2, 8'h03);
        tick();
        chk("cnt_after_clr", {62'd0, conflict_cnt}, 64'd1);

        // Asynchronous reset with two beats in flight
        out_ready = 1'b0;
        set_lane(0, 10'h005);
        set_lane(1, 10'h005);
        in_en    = 8'h03;
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
        rst = 1'b0;
        #1;
        chk("async_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("async_rst_cnt", {62'd0, conflict_cnt}, 64'd0);
        tick();
        rst       = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("post_rst_ready", {63'd0, in_ready}, 64'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("no_stale_beat", {63'd0, out_valid}, 64'd0);
        end
        in_addr = '0;
        set_lane(0, 10'h006);
        beat(2'd2, 8'h01);
        chk("post_rst_valid", {63'd0, out_valid}, 64'd1);
        chk("post_rst_bank", {61'd0, out_bank[2:0]}, 64'd6);
        tick();
        chk("post_rst_drained", {63'd0, out_valid}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/conflict_free_map_pipe.md
# conflict_free_map_pipe

Parametrised, handshaked successor to the single-cycle bank mapper. It splits each of LANES flat coefficient addresses into a bank number and an in-bank row address, using one of three runtime-selectable bank schemes. It passes the results through a 2-stage valid/ready pipeline with backpressure and flags any beat whose enabled lanes collide on a bank. It sits between the NTT address generators and the banked coefficient RAMs.

## Interface
- LANES, 8, number of address lanes per beat (≥2)
- ADDR_W, 10, flat address width
- BANK_W, 3, bank index width; banks = 2^BANK_W; ADDR_W > BANK_W
- CNT_W, 16, conflict counter width
- clk  in  1  clock
- rst  in  1  reset; one clock, reset asynchronous and active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_mode  in  2  bank scheme for this beat: 0 parity-flip, 1 digit-sum skew, 2/3 identity
- in_en  in  LANES  per-lane enable; disabled lanes excluded from conflict check
- in_addr  in  LANES*ADDR_W  lane i at [i*ADDR_W +: ADDR_W]
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_en  out  LANES  in_en carried with the beat
- out_bank  out  LANES*BANK_W  lane i at [i*BANK_W +: BANK_W]
- out_row  out  LANES*(ADDR_W-BANK_W)  lane i at [i*(ADDR_W-BANK_W) +: ADDR_W-BANK_W]
- out_conflict  out  1  ≥2 enabled lanes of this beat share a bank
- cnt_clr  in  1  synchronous clear of conflict_cnt
- conflict_cnt  out  CNT_W  saturating count of conflicting beats handed off

## Operation
- Row: row = addr >> BANK_W (upper ADDR_W-BANK_W bits), in every mode.
- Mode 0: p = XOR of addr[ADDR_W-1:BANK_W]; bank = addr[BANK_W-1:0] with bit BANK_W-1 inverted when p=1.
- Mode 1: split addr into ceil(ADDR_W/BANK_W) BANK_W-bit digits from LSB, top digit zero-padded; bank = sum of digits mod 2^BANK_W.
- Mode 2, 3: bank = addr[BANK_W-1:0].
- Mode is sampled per beat at acceptance and travels with it. Mode changes between beats are legal with no flush.
- Stage 1 registers bank, row, en. Stage 2 registers the stage-1 fields plus out_conflict, computed from stage-1 banks: OR over all pairs i<j of en[i]&en[j]&(bank[i]==bank[j]).
- conflict_cnt increments by 1 on each handoff (out_valid && out_ready) with out_conflict=1, and saturates at 2^CNT_W-1. cnt_clr forces it to 0 and wins over a same-cycle increment.

## Timing
- Reset (rst low, asynchronous): both stage valids 0, all data registers 0, conflict_cnt 0. Outputs are then out_valid 0, out_bank/out_row/out_en/out_conflict 0, in_ready 1.
- Advance rules: adv2 = !v2 || out_ready; adv1 = !v1 || adv2; in_ready = adv1. in_ready is combinational from out_ready.
- Latency: a beat accepted at edge k, with no stall, is presented at out_valid after edge k+1, i.e. 2 cycles from input sample to output registers.
- Throughput: 1 beat/cycle when out_ready is held 1.
- Stall: with out_ready=0, up to 2 beats are buffered. in_ready falls once both stages are valid. Held output data must stay stable while out_valid && !out_ready.
- Bubbles collapse: an empty stage 2 loads from stage 1 regardless of out_ready.
- Order is strictly preserved, with no drop and no duplication.
- Reset mid-stream discards all in-flight beats. There is no output activity until new input arrives.
- A beat with in_en all 0 still flows, with out_conflict=0.

## Test plan
- Mode 0, lane0 addr 0x009, lane1 addr 0x000, en=0x03 -> bank 5 row 1 on lane 0; bank 0 row 0 on lane 1; out_conflict 0; out_valid 2 cycles after accept.
- Mode 1, lane0 addr 0x009 -> bank 2, row 1. Mode 2, lane0 0x000 and lane1 0x008, en=0x03 -> both bank 0, out_conflict 1, conflict_cnt 1 after handoff. Same addresses in mode 0 -> banks 0 and 4, no conflict.
- Mode 2, lanes 0..7 addr 0..7, en=0xFF -> banks 0..7, out_conflict 0. Repeat with en=0x00 and all addr 0 -> out_conflict 0.
- Backpressure: out_ready=0, offer beats A,B,C back-to-back -> A,B accepted, in_ready 0 on C; out_valid 1 holding A stable. Then out_ready=1 -> A,B,C emitted on consecutive cycles, in order.
- Counter: CNT_W=2, 5 conflicting beats -> conflict_cnt saturates at 3. cnt_clr asserted in the same cycle as a conflicting handoff -> 0.
- Assert rst low with 2 beats in flight -> out_valid 0 and conflict_cnt 0 immediately, without waiting for a clock edge. After release, in_ready 1 and the stale beats never appear.
